// File: rtl/bmr_tdee_mem_pkg.sv
// Shared constants and state type for the on-chip memory block-copy master.
package bmr_tdee_mem_pkg;

    localparam int MEM_ADDR_W = 14;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_DEPTH  = 10024;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } copy_state_e;

endpackage

// File: rtl/bmr_tdee_copy_range_chk.sv
// Combinational legality check of a copy command (empty, out of range, unsafe overlap).
module bmr_tdee_copy_range_chk
    import bmr_tdee_mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DEPTH  = MEM_DEPTH
) (
    input  logic [ADDR_W-1:0] src_i,
    input  logic [ADDR_W-1:0] dst_i,
    input  logic [ADDR_W:0]   len_i,
    output logic              reject_o,
    output logic              is_empty_o
);
    // Two extra bits: max src plus max len cannot overflow the sum.
    localparam int SUM_W = ADDR_W + 2;

    logic [SUM_W-1:0] src_end;
    logic [SUM_W-1:0] dst_end;
    logic [SUM_W-1:0] depth_w;
    logic             out_of_range;
    logic             overlap;

    assign depth_w      = SUM_W'(DEPTH);
    assign src_end      = SUM_W'(src_i) + SUM_W'(len_i);
    assign dst_end      = SUM_W'(dst_i) + SUM_W'(len_i);
    assign out_of_range = (src_end > depth_w) || (dst_end > depth_w);
    // A forward copy is only corrupted when dst lands inside the source window.
    assign overlap      = (src_i < dst_i) && (SUM_W'(dst_i) < src_end);
    assign is_empty_o   = (len_i == '0);
    assign reject_o     = is_empty_o || out_of_range || overlap;

endmodule

// File: rtl/bmr_tdee_mem_copy_master.sv
// Avalon-MM initiator copying a block of words within the single-port on-chip memory.
// Define MEM_COPY_CHECKSUM_EN to build the additive checksum of copied words.
module bmr_tdee_mem_copy_master
    import bmr_tdee_mem_pkg::*;
#(
    parameter int ADDR_W       = MEM_ADDR_W,
    parameter int DATA_W       = MEM_DATA_W,
    parameter int DEPTH        = MEM_DEPTH,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic [ADDR_W-1:0]   src_i,
    input  logic [ADDR_W-1:0]   dst_i,
    input  logic [ADDR_W:0]     len_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [DATA_W-1:0]   checksum_o,
    output logic [ADDR_W-1:0]   address_o,
    output logic [DATA_W/8-1:0] byteenable_o,
    output logic                chipselect_o,
    output logic                write_o,
    output logic [DATA_W-1:0]   writedata_o,
    input  logic [DATA_W-1:0]   readdata_i,
    output logic                clken_o
);
    localparam int LAT_W = 2;

    copy_state_e       state_q, state_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [ADDR_W-1:0] dp_q, dp_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              err_q, err_d;

    logic reject;
    logic is_empty;
    logic accept;
    logic capture;

    bmr_tdee_copy_range_chk #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_range_chk (
        .src_i      (src_i),
        .dst_i      (dst_i),
        .len_i      (len_i),
        .reject_o   (reject),
        .is_empty_o (is_empty)
    );

    assign accept  = (state_q == ST_IDLE) && start_i && !reject;
    assign capture = (state_q == ST_WAIT) && (lat_q == '0);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_i) state_d = reject ? ST_DONE : ST_READ;
            ST_READ:  state_d = ST_WAIT;
            ST_WAIT:  if (lat_q == '0) state_d = ST_WRITE;
            ST_WRITE: state_d = (rem_q == (ADDR_W+1)'(1)) ? ST_DONE : ST_READ;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Bus strobes drop in the reset cycle itself so an interrupted write never lands.
    always_comb begin
        busy_o       = (state_q == ST_READ) || (state_q == ST_WAIT) || (state_q == ST_WRITE);
        done_o       = (state_q == ST_DONE);
        err_o        = (state_q == ST_DONE) && err_q;
        chipselect_o = ((state_q == ST_READ) || (state_q == ST_WRITE)) && !reset_i;
        write_o      = (state_q == ST_WRITE) && !reset_i;
        address_o    = '0;
        writedata_o  = '0;
        if (state_q == ST_READ) begin
            address_o = sp_q;
        end else if (state_q == ST_WRITE) begin
            address_o   = dp_q;
            writedata_o = data_q;
        end
        byteenable_o = '1;
        clken_o      = 1'b1;
    end

    always_comb begin
        sp_d   = sp_q;
        dp_d   = dp_q;
        rem_d  = rem_q;
        data_d = data_q;
        lat_d  = lat_q;
        err_d  = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    sp_d  = src_i;
                    dp_d  = dst_i;
                    rem_d = len_i;
                    err_d = reject && !is_empty;
                end
            end
            ST_READ:  lat_d = LAT_W'(READ_LATENCY - 1);
            ST_WAIT: begin
                if (lat_q == '0) begin
                    data_d = readdata_i;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            ST_WRITE: begin
                sp_d  = sp_q + ADDR_W'(1);
                dp_d  = dp_q + ADDR_W'(1);
                rem_d = rem_q - (ADDR_W+1)'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sp_q   <= '0;
            dp_q   <= '0;
            rem_q  <= '0;
            data_q <= '0;
            lat_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            sp_q   <= sp_d;
            dp_q   <= dp_d;
            rem_q  <= rem_d;
            data_q <= data_d;
            lat_q  <= lat_d;
            err_q  <= err_d;
        end
    end

`ifdef MEM_COPY_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (accept) begin
            sum_d = '0;
        end else if (capture) begin
            sum_d = sum_q + readdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum_o = sum_q;
`else
    logic unused_sum;
    assign unused_sum = accept ^ capture;
    assign checksum_o = '0;
`endif

endmodule
